// File: rtl/wash_prog_ctrl.sv
// Washing-machine program sequencer: FILL -> WASH -> RINSE -> SPIN -> DONE with
// pause, door interlock, fill timeout and a sticky FAULT state.
module wash_prog_ctrl #(
    parameter int FILL_TMO = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] prog,
    input  logic       pause,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic       clr_fault,
    output logic [2:0] phase,
    output logic       valve_on,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [3:0] FILL_LAST = 4'(FILL_TMO - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] prog_q, prog_d;

    // Number of unpaused cycles spent in each timed phase for each program.
    function automatic logic [3:0] phase_len(input logic [1:0] p, input state_t s);
        logic [3:0] len;
        len = 4'd1;
        case (p)
            2'd0: begin
                case (s)
                    S_WASH:  len = 4'd4;
                    S_RINSE: len = 4'd3;
                    S_SPIN:  len = 4'd4;
                    default: len = 4'd1;
                endcase
            end
            2'd1: begin
                case (s)
                    S_WASH:  len = 4'd8;
                    S_RINSE: len = 4'd5;
                    S_SPIN:  len = 4'd8;
                    default: len = 4'd1;
                endcase
            end
            2'd2: begin
                case (s)
                    S_WASH:  len = 4'd12;
                    S_RINSE: len = 4'd6;
                    S_SPIN:  len = 4'd10;
                    default: len = 4'd1;
                endcase
            end
            default: len = 4'd1;
        endcase
        return len;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            prog_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prog_q  <= prog_d;
        end
    end

    // Door interlock beats pause, pause beats progress; the counter restarts on any phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prog_d  = prog_q;
        case (state_q)
            S_IDLE: begin
                if (start && door_closed && (prog != 2'd3)) begin
                    state_d = S_FILL;
                    prog_d  = prog;
                end
            end
            S_FILL: begin
                if (!door_closed) begin
                    state_d = S_FAULT;
                end else if (!pause) begin
                    if (water_full) begin
                        state_d = S_WASH;
                    end else if (cnt_q == FILL_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (!door_closed) begin
                    state_d = S_FAULT;
                end else if (!pause) begin
                    if (cnt_q == phase_len(prog_q, state_q) - 4'd1) begin
                        case (state_q)
                            S_WASH:  state_d = S_RINSE;
                            S_RINSE: state_d = S_SPIN;
                            default: state_d = S_DONE;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end
    end

    always_comb begin
        valve_on   = 1'b0;
        motor_on   = 1'b0;
        motor_fast = 1'b0;
        door_lock  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_FILL: begin
                valve_on  = !pause;
                door_lock = 1'b1;
                busy      = 1'b1;
            end
            S_WASH, S_RINSE: begin
                motor_on  = !pause;
                door_lock = 1'b1;
                busy      = 1'b1;
            end
            S_SPIN: begin
                motor_on   = !pause;
                motor_fast = !pause;
                door_lock  = 1'b1;
                busy       = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: doc/wash_prog_ctrl.md
WASH_PROG_CTRL -- requirements
Module: wash_prog_ctrl

Interface
REQ-001 The block SHALL have parameter FILL_TMO, default 15, legal range 2..15: maximum unpaused FILL cycles before a fill fault.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: cycle request to begin a program.
REQ-005 The block SHALL have port prog, input, 2 bits: program select (0 quick, 1 normal, 2 heavy, 3 reserved).
REQ-006 The block SHALL have port pause, input, 1 bit: level; freezes the active phase.
REQ-007 The block SHALL have port door_closed, input, 1 bit: door sensor (1 = closed).
REQ-008 The block SHALL have port water_full, input, 1 bit: level sensor (1 = drum full).
REQ-009 The block SHALL have port clr_fault, input, 1 bit: fault acknowledge.
REQ-010 The block SHALL have port phase, output, 3 bits: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DONE, 7 FAULT.
REQ-011 The block SHALL have ports valve_on, motor_on, motor_fast, door_lock, busy, done and fault, each an output of 1 bit: actuator and status flags.

Function
REQ-012 The FSM SHALL have states IDLE, FILL, WASH, RINSE, SPIN, DONE and FAULT; phase SHALL be the registered state encoding.
REQ-013 In IDLE, start=1 with door_closed=1 and prog!=3 SHALL latch prog and enter FILL on the next edge; any other start condition SHALL leave the FSM in IDLE.
REQ-014 prog SHALL be ignored outside the IDLE acceptance edge; the latched program SHALL hold until the FSM returns to IDLE.
REQ-015 Phase durations in unpaused cycles SHALL be: prog 0 WASH 4, RINSE 3, SPIN 4; prog 1 WASH 8, RINSE 5, SPIN 8; prog 2 WASH 12, RINSE 6, SPIN 10.
REQ-016 A 4-bit phase counter SHALL clear on every phase entry and increment only on unpaused cycles; WASH, RINSE and SPIN SHALL exit after exactly the tabled number of unpaused cycles.
REQ-017 FILL SHALL go to WASH on the first unpaused FILL cycle with water_full=1.
REQ-018 FILL SHALL go to FAULT if water_full=0 on the FILL_TMO-th unpaused FILL cycle.
REQ-019 Sequence SHALL be FILL->WASH->RINSE->SPIN->DONE; DONE SHALL last exactly one cycle, then go to IDLE.
REQ-020 Priority in FILL..SPIN SHALL be door_closed=0 (go to FAULT next edge, even if paused) > pause (hold state and counter) > normal progress.
REQ-021 FAULT SHALL hold until clr_fault=1, then go to IDLE on the next edge; start SHALL be ignored in FAULT.
REQ-022 valve_on SHALL be 1 only in FILL with pause=0.
REQ-023 motor_on SHALL be 1 only in WASH, RINSE or SPIN with pause=0.
REQ-024 motor_fast SHALL be 1 only in SPIN with pause=0.
REQ-025 door_lock and busy SHALL be 1 in FILL, WASH, RINSE and SPIN, including while paused, and 0 otherwise.
REQ-026 done SHALL be 1 only in DONE; fault SHALL be 1 only in FAULT.
REQ-027 pause, door_closed and water_full SHALL be used combinationally for outputs and next state, with no added latency.
REQ-028 Unused encoding 6 SHALL recover to IDLE on the next edge.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, a cleared counter, latched prog=0 and every output 0, from any state including mid-phase.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge per REQ-013.

Verification
REQ-031 Quick program: prog=0 and start at edge 0, water_full=1 from cycle 3 -> FILL cycles 1-3, WASH 4-7, RINSE 8-10, SPIN 11-14 with motor_fast=1, done=1 in cycle 15, IDLE in cycle 16.
REQ-032 Pause: prog=1 with pause=1 for 5 cycles mid-WASH -> WASH lasts 13 cycles, motor_on=0 and door_lock=1 while paused, phase stays 2.
REQ-033 Fill timeout: water_full held 0 with FILL_TMO=15 -> 15 FILL cycles with valve_on=1, then phase=7 and fault=1; clr_fault=1 -> IDLE next cycle.
REQ-034 Door fault: door_closed=0 in SPIN -> phase=7 next cycle, motor_on=0, door_lock=0; start is ignored until clr_fault.
REQ-035 Rejected start: start with prog=3, or with door_closed=0 -> phase stays 0 and all outputs stay 0.
REQ-036 Reset mid-run: rst pulsed in RINSE -> all outputs 0 at once; a new start with prog=2 runs a full WASH of 12 cycles.
